// File: rtl/fifo_rr_pop_ctrl_pkg.sv
// Shared constants for the round-robin pop controller: one-hot state codes,
// threshold width and default data width.
package fifo_rr_pop_ctrl_pkg;

    localparam int THR_W      = 4;
    localparam int DW_DEFAULT = 6;
    localparam int STATE_W    = 5;

    localparam logic [STATE_W-1:0] ST_RESET  = 5'b00001;
    localparam logic [STATE_W-1:0] ST_INIT   = 5'b00010;
    localparam logic [STATE_W-1:0] ST_IDLE   = 5'b00100;
    localparam logic [STATE_W-1:0] ST_ACTIVE = 5'b01000;
    localparam logic [STATE_W-1:0] ST_ERROR  = 5'b10000;

endpackage

// File: rtl/fifo_rr_pop_ctrl_if.sv
// Handshake bundle between the pop controller, its N input FIFOs and the
// shared output FIFO.
interface fifo_rr_pop_ctrl_if
    import fifo_rr_pop_ctrl_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = 2,
    parameter int DW = DW_DEFAULT
);

    logic [N-1:0]    fifo_empty_in;
    logic [N-1:0]    fifo_error_in;
    logic [N*DW-1:0] fifo_data_in;
    logic [N-1:0]    pop;
    logic            out_almost_full;
    logic            out_error;
    logic            push_out;
    logic [DW-1:0]   data_out;
    logic [SW-1:0]   sel;

    modport master (
        input  fifo_empty_in,
        input  fifo_error_in,
        input  fifo_data_in,
        input  out_almost_full,
        input  out_error,
        output pop,
        output push_out,
        output data_out,
        output sel
    );

    modport slave (
        output fifo_empty_in,
        output fifo_error_in,
        output fifo_data_in,
        output out_almost_full,
        output out_error,
        input  pop,
        input  push_out,
        input  data_out,
        input  sel
    );

endinterface

// File: rtl/fifo_rr_pop_ctrl_rr_grant.sv
// Rotating-priority encoder: grants the first eligible index found scanning
// upward from rr_ptr, wrapping modulo N.
module fifo_rr_pop_ctrl_rr_grant #(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic [N-1:0]  eligible,
    input  logic [SW-1:0] rr_ptr,
    output logic          grant_valid,
    output logic [SW-1:0] grant_idx
);

    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(rr_ptr) + k) % N;
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = SW'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_rr_pop_ctrl.sv
// Shares one output FIFO between N input FIFOs: round-robin pops, one-cycle
// push pipeline matching the RAM read latency, threshold capture, sticky error.
module fifo_rr_pop_ctrl
    import fifo_rr_pop_ctrl_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = 2,
    parameter int DW = DW_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init,
    input  logic [THR_W-1:0]   umbral_af_in,
    input  logic [THR_W-1:0]   umbral_ae_in,
    fifo_rr_pop_ctrl_if.master bus,
    output logic [THR_W-1:0]   umbral_af_out,
    output logic [THR_W-1:0]   umbral_ae_out,
    output logic [STATE_W-1:0] state,
    output logic               error_out
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [SW-1:0]      rr_ptr;
    logic [SW-1:0]      sel_q;
    logic               push_q;
    logic [THR_W-1:0]   af_q;
    logic [THR_W-1:0]   ae_q;

    logic [N-1:0]       eligible;
    logic               grant_valid;
    logic [SW-1:0]      grant_idx;
    logic               grant_fire;
    logic [N-1:0]       pop_d;
    logic               err_any;
    logic               all_empty;

    assign err_any   = (|bus.fifo_error_in) | bus.out_error;
    assign all_empty = &bus.fifo_empty_in;
    assign eligible  = ~bus.fifo_empty_in & {N{~bus.out_almost_full}};

    fifo_rr_pop_ctrl_rr_grant #(
        .N  (N),
        .SW (SW)
    ) u_rr_grant (
        .eligible    (eligible),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Error inputs also suppress the pop, so no word leaves an input FIFO in
    // the cycle that commits to ERROR and then gets dropped.
    assign grant_fire = (state_q == ST_ACTIVE) && !err_any && grant_valid;
    assign pop_d      = grant_fire ? (N'(1) << grant_idx) : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                if (err_any)
                    state_d = ST_ERROR;
                else if (!init)
                    state_d = (af_q <= ae_q) ? ST_ERROR : ST_IDLE;
            end
            ST_IDLE: begin
                if (err_any)
                    state_d = ST_ERROR;
                else if (init)
                    state_d = ST_INIT;
                else if (!all_empty)
                    state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (err_any)
                    state_d = ST_ERROR;
                else if (all_empty && !grant_fire)
                    state_d = ST_IDLE;
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RESET;
            rr_ptr  <= '0;
            sel_q   <= '0;
            push_q  <= 1'b0;
            af_q    <= '0;
            ae_q    <= '0;
        end else begin
            state_q <= state_d;
            push_q  <= grant_fire;
            if (grant_fire) begin
                sel_q  <= grant_idx;
                rr_ptr <= (grant_idx == SW'(N - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (state_q == ST_INIT && init) begin
                af_q <= umbral_af_in;
                ae_q <= umbral_ae_in;
            end
        end
    end

    assign bus.pop      = pop_d;
    assign bus.push_out = push_q;
    assign bus.sel      = sel_q;
    assign bus.data_out = bus.fifo_data_in[int'(sel_q)*DW +: DW];

    assign umbral_af_out = af_q;
    assign umbral_ae_out = ae_q;
    assign state         = state_q;
    assign error_out     = (state_q == ST_ERROR);

endmodule

// File: tb/tb_fifo_rr_pop_ctrl.sv
// Self-checking bench for fifo_rr_pop_ctrl: scenario tasks with a scoreboard
// queue of expected pushes filled on each expected pop.
module tb_fifo_rr_pop_ctrl;

    localparam logic [4:0] S_RESET  = 5'b00001;
    localparam logic [4:0] S_INIT   = 5'b00010;
    localparam logic [4:0] S_IDLE   = 5'b00100;
    localparam logic [4:0] S_ACTIVE = 5'b01000;
    localparam logic [4:0] S_ERROR  = 5'b10000;

    typedef struct packed {
        logic [1:0] sel;
        logic [5:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic [3:0] af_in;
    logic [3:0] ae_in;
    logic [3:0] af_out;
    logic [3:0] ae_out;
    logic [4:0] state;
    logic       error_out;
    logic [5:0] qdata [4];
    exp_t       sb [$];
    int         n_checks = 0;
    int         n_fail   = 0;

    fifo_rr_pop_ctrl_if #(.N(4), .SW(2), .DW(6)) bus ();

    fifo_rr_pop_ctrl #(.N(4), .SW(2), .DW(6)) dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .umbral_af_in  (af_in),
        .umbral_ae_in  (ae_in),
        .bus           (bus),
        .umbral_af_out (af_out),
        .umbral_ae_out (ae_out),
        .state         (state),
        .error_out     (error_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [5:0] salt);
        for (int i = 0; i < 4; i++) begin
            qdata[i] = 6'(i * 13) + salt;
            bus.fifo_data_in[i*6 +: 6] = qdata[i];
        end
    endtask

    task automatic bring_up();
        bus.fifo_empty_in   = '1;
        bus.fifo_error_in   = '0;
        bus.out_almost_full = 1'b0;
        bus.out_error       = 1'b0;
        reset = 1'b1;
        init  = 1'b0;
        tick();
        reset = 1'b0;
        init  = 1'b1;
        af_in = 4'd6;
        ae_in = 4'd2;
        tick();
        tick();
        init = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        init  = 1'b0;
        af_in = 4'd0;
        ae_in = 4'd0;
        bus.fifo_empty_in   = '1;
        bus.fifo_error_in   = '0;
        bus.out_almost_full = 1'b0;
        bus.out_error       = 1'b0;
        set_data(6'd1);
        tick();
        tick();
        n_checks++;
        if (state !== S_RESET) begin n_fail++; $display("FAIL reset_state: got %b expected %b", state, S_RESET); end
        n_checks++;
        if (bus.pop !== 4'b0000 || bus.push_out !== 1'b0 || bus.sel !== 2'd0) begin
            n_fail++; $display("FAIL reset_outputs: got pop=%b push=%b sel=%0d expected 0/0/0", bus.pop, bus.push_out, bus.sel);
        end
        n_checks++;
        if (af_out !== 4'd0 || ae_out !== 4'd0 || error_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_regs: got af=%0d ae=%0d err=%b expected 0/0/0", af_out, ae_out, error_out);
        end
    endtask

    task automatic test_config();
        reset = 1'b0;
        init  = 1'b1;
        af_in = 4'd6;
        ae_in = 4'd2;
        tick();
        n_checks++;
        if (state !== S_INIT || af_out !== 4'd0) begin
            n_fail++; $display("FAIL cfg_enter_init: got state=%b af=%0d expected %b/0", state, af_out, S_INIT);
        end
        tick();
        n_checks++;
        if (af_out !== 4'd6 || ae_out !== 4'd2) begin
            n_fail++; $display("FAIL cfg_load: got af=%0d ae=%0d expected 6/2", af_out, ae_out);
        end
        init = 1'b0;
        tick();
        n_checks++;
        if (state !== S_IDLE) begin n_fail++; $display("FAIL cfg_idle: got %b expected %b", state, S_IDLE); end
        af_in = 4'd9;
        ae_in = 4'd1;
        tick();
        n_checks++;
        if (af_out !== 4'd6 || ae_out !== 4'd2 || state !== S_IDLE) begin
            n_fail++; $display("FAIL cfg_hold_idle: got af=%0d ae=%0d state=%b expected 6/2/%b", af_out, ae_out, state, S_IDLE);
        end
        init = 1'b1;
        tick();
        n_checks++;
        if (state !== S_INIT) begin n_fail++; $display("FAIL cfg_reinit: got %b expected %b", state, S_INIT); end
        tick();
        init = 1'b0;
        tick();
        n_checks++;
        if (state !== S_IDLE || af_out !== 4'd9 || ae_out !== 4'd1) begin
            n_fail++; $display("FAIL cfg_reload: got state=%b af=%0d ae=%0d expected %b/9/1", state, af_out, ae_out, S_IDLE);
        end
    endtask

    task automatic test_config_error();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        init  = 1'b1;
        af_in = 4'd3;
        ae_in = 4'd3;
        tick();
        tick();
        init = 1'b0;
        tick();
        n_checks++;
        if (state !== S_ERROR || error_out !== 1'b1) begin
            n_fail++; $display("FAIL cfgerr_enter: got state=%b err=%b expected %b/1", state, error_out, S_ERROR);
        end
        bus.fifo_empty_in = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (state !== S_ERROR || bus.pop !== 4'b0000 || bus.push_out !== 1'b0) begin
                n_fail++; $display("FAIL cfgerr_sticky[%0d]: got state=%b pop=%b push=%b expected %b/0000/0", i, state, bus.pop, bus.push_out, S_ERROR);
            end
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (state !== S_RESET || error_out !== 1'b0) begin
            n_fail++; $display("FAIL cfgerr_reset: got state=%b err=%b expected %b/0", state, error_out, S_RESET);
        end
        reset = 1'b0;
        bus.fifo_empty_in = '1;
    endtask

    // Pattern 0: all queues busy; 1: queue 2 alone then queue 0 joins;
    // 2: almost-full pause in the middle of a full stream.
    task automatic test_pop_patterns();
        logic [3:0] e_tab [3][7];
        logic       a_tab [3][7];
        logic [3:0] p_tab [3][7];
        int         s_tab [3][7];
        int         len   [3];
        exp_t       e;
        e_tab = '{'{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0},
                  '{4'hB, 4'hB, 4'hB, 4'hA, 4'hA, 4'hA, 4'hF},
                  '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0}};
        a_tab = '{'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
                  '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
                  '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}};
        p_tab = '{'{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0},
                  '{4'h4, 4'h4, 4'h4, 4'h1, 4'h4, 4'h1, 4'h0},
                  '{4'h1, 4'h2, 4'h0, 4'h0, 4'h4, 4'h8, 4'h1}};
        s_tab = '{'{0, 1, 2, 3, 0, 0, 0},
                  '{2, 2, 2, 0, 2, 0, 0},
                  '{0, 1, 0, 0, 2, 3, 0}};
        len   = '{5, 6, 7};
        for (int t = 0; t < 3; t++) begin
            bring_up();
            set_data(6'(t * 7 + 3));
            sb.delete();
            bus.fifo_empty_in   = e_tab[t][0];
            bus.out_almost_full = a_tab[t][0];
            tick();
            n_checks++;
            if (state !== S_ACTIVE) begin n_fail++; $display("FAIL pat%0d_active: got %b expected %b", t, state, S_ACTIVE); end
            for (int c = 0; c < len[t]; c++) begin
                bus.fifo_empty_in   = e_tab[t][c];
                bus.out_almost_full = a_tab[t][c];
                #1;
                n_checks++;
                if (bus.pop !== p_tab[t][c]) begin
                    n_fail++; $display("FAIL pat%0d_pop[%0d]: got %b expected %b", t, c, bus.pop, p_tab[t][c]);
                end
                if (p_tab[t][c] != 4'h0)
                    sb.push_back('{sel: 2'(s_tab[t][c]), data: qdata[s_tab[t][c]]});
                tick();
                n_checks++;
                if (bus.push_out !== (sb.size() != 0)) begin
                    n_fail++; $display("FAIL pat%0d_push[%0d]: got %b expected %b", t, c, bus.push_out, sb.size() != 0);
                end else if (sb.size() != 0) begin
                    e = sb.pop_front();
                    n_checks++;
                    if (bus.sel !== e.sel || bus.data_out !== e.data) begin
                        n_fail++; $display("FAIL pat%0d_word[%0d]: got sel=%0d data=%h expected sel=%0d data=%h", t, c, bus.sel, bus.data_out, e.sel, e.data);
                    end
                end
            end
            bus.fifo_empty_in   = '1;
            bus.out_almost_full = 1'b0;
            #1;
            n_checks++;
            if (bus.pop !== 4'b0000) begin n_fail++; $display("FAIL pat%0d_drain_pop: got %b expected 0000", t, bus.pop); end
            tick();
            n_checks++;
            if (bus.push_out !== 1'b0 || state !== S_IDLE) begin
                n_fail++; $display("FAIL pat%0d_idle: got push=%b state=%b expected 0/%b", t, bus.push_out, state, S_IDLE);
            end
        end
    endtask

    task automatic test_error_and_midreset();
        bring_up();
        set_data(6'd20);
        bus.fifo_empty_in = 4'b0000;
        tick();
        n_checks++;
        if (bus.pop !== 4'b0001) begin n_fail++; $display("FAIL err_first_pop: got %b expected 0001", bus.pop); end
        tick();
        n_checks++;
        if (bus.push_out !== 1'b1 || bus.sel !== 2'd0 || bus.data_out !== qdata[0]) begin
            n_fail++; $display("FAIL err_first_push: got push=%b sel=%0d data=%h expected 1/0/%h", bus.push_out, bus.sel, bus.data_out, qdata[0]);
        end
        bus.fifo_error_in = 4'b0010;
        tick();
        n_checks++;
        if (state !== S_ERROR || error_out !== 1'b1 || bus.pop !== 4'b0000 || bus.push_out !== 1'b0) begin
            n_fail++; $display("FAIL err_enter: got state=%b err=%b pop=%b push=%b expected %b/1/0000/0", state, error_out, bus.pop, bus.push_out, S_ERROR);
        end
        bus.fifo_error_in = 4'b0000;
        tick();
        n_checks++;
        if (state !== S_ERROR || bus.pop !== 4'b0000) begin
            n_fail++; $display("FAIL err_sticky: got state=%b pop=%b expected %b/0000", state, bus.pop, S_ERROR);
        end

        bring_up();
        bus.fifo_empty_in = 4'b0000;
        tick();
        tick();
        n_checks++;
        if (bus.pop !== 4'b0010 || bus.push_out !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre: got pop=%b push=%b expected 0010/1", bus.pop, bus.push_out);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (state !== S_RESET || bus.push_out !== 1'b0 || bus.pop !== 4'b0000 || bus.sel !== 2'd0) begin
            n_fail++; $display("FAIL mid_reset: got state=%b push=%b pop=%b sel=%0d expected %b/0/0000/0", state, bus.push_out, bus.pop, bus.sel, S_RESET);
        end
        n_checks++;
        if (af_out !== 4'd0 || ae_out !== 4'd0) begin
            n_fail++; $display("FAIL mid_reset_thr: got af=%0d ae=%0d expected 0/0", af_out, ae_out);
        end
        reset = 1'b0;
        init  = 1'b1;
        tick();
        tick();
        init = 1'b0;
        tick();
        n_checks++;
        if (state !== S_IDLE || bus.pop !== 4'b0000) begin
            n_fail++; $display("FAIL mid_idle: got state=%b pop=%b expected %b/0000", state, bus.pop, S_IDLE);
        end
        tick();
        n_checks++;
        if (state !== S_ACTIVE || bus.pop !== 4'b0001) begin
            n_fail++; $display("FAIL mid_rrptr: got state=%b pop=%b expected %b/0001", state, bus.pop, S_ACTIVE);
        end
        bus.fifo_empty_in = '1;
    endtask

    initial begin
        test_reset();
        test_config();
        test_config_error();
        test_pop_patterns();
        test_error_and_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rr_pop_ctrl.md
Name: fifo_rr_pop_ctrl

Overview:
Flow-control scheduler that shares one downstream output FIFO between N upstream fifo_c-style queues.
- Captures the almost-full/almost-empty thresholds and distributes them to all FIFOs.
- Pops the non-empty input FIFOs round-robin, at most one pop per cycle, gated by downstream almost-full (pause).
- Pushes each popped word into the output FIFO one cycle later, after the synchronous RAM read latency.
- Aggregates FIFO error flags into a sticky error state.

Parameters:
N, 4, number of input FIFOs; supported values 2..8.
SW, 2, select width; must equal clog2(N).
DW, 6, data width of every FIFO.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
init  in  1  configuration window; thresholds are loaded while high.
umbral_af_in  in  4  almost-full threshold to load.
umbral_ae_in  in  4  almost-empty threshold to load.
fifo_empty_in  in  N  per-input-FIFO empty flag.
fifo_error_in  in  N  per-input-FIFO error flag.
fifo_data_in  in  N*DW  flattened input FIFO read data; queue i occupies bits [i*DW +: DW].
out_almost_full  in  1  almost-full/pause flag from the output FIFO.
out_error  in  1  error flag from the output FIFO.
pop  out  N  one-hot pop strobe to the input FIFOs.
push_out  out  1  push strobe to the output FIFO.
data_out  out  DW  data to the output FIFO; valid when push_out=1.
sel  out  SW  index of the queue currently being pushed.
umbral_af_out  out  4  registered almost-full threshold broadcast to all FIFOs.
umbral_ae_out  out  4  registered almost-empty threshold broadcast to all FIFOs.
state  out  5  one-hot state, for debug and for the bench.
error_out  out  1  high while in ERROR.

Behaviour:
Reset:
- reset=1 at a clock edge (including mid-transfer) forces the following: state=RESET, rr_ptr=0, umbral regs=0, push_out=0, sel=0, pop=0, error_out=0.
- Any in-flight push is discarded.

States are one-hot: RESET=00001, INIT=00010, IDLE=00100, ACTIVE=01000, ERROR=10000.
- RESET -> INIT on the first edge with reset=0.
- INIT:
  - While init=1, umbral_af/ae regs load from the inputs every cycle. pop=0.
  - When init=0: if umbral_af <= umbral_ae -> ERROR (configuration error); else -> IDLE.
- IDLE:
  - init=1 -> INIT.
  - Else if any fifo_empty_in=0 -> ACTIVE.
  - pop=0.
- ACTIVE:
  - eligible[i] = !fifo_empty_in[i] && !out_almost_full.
  - Grant the first eligible index scanning rr_ptr, rr_ptr+1, ... mod N.
  - pop = onehot(grant), combinational, same cycle.
  - On a grant: rr_ptr <= (grant+1) mod N. With no grant, rr_ptr holds.
  - -> IDLE when all fifo_empty_in=1 and push_out will be 0 next cycle.
  - init is ignored in ACTIVE.
- ERROR:
  - Entered from INIT, IDLE or ACTIVE when any fifo_error_in=1 or out_error=1; error has priority over all other transitions.
  - Sticky until reset.
  - pop=0, push_out=0 from the cycle after entry; error_out=1.

Push path, one-cycle latency:
- push_out <= |pop; sel <= grant index.
- data_out = fifo_data_in[sel*DW +: DW], combinational from the registered sel.
- Back-to-back pops produce back-to-back pushes.

Back-pressure:
- out_almost_full=1 blocks new pops in the same cycle.
- A push already registered still completes; the output FIFO threshold margin covers it.

Fixed rules:
- Never more than one pop bit high.
- pop is never asserted to a queue whose fifo_empty_in=1.
- umbral outputs change only in INIT.

Decomposition:
Shared package holds:
- state encodings RESET/INIT/IDLE/ACTIVE/ERROR as 5-bit localparams;
- threshold width 4;
- default DW=6.

One sub-module, rr_grant: combinational rotating-priority encoder.
- Inputs: eligible[N], rr_ptr[SW].
- Outputs: grant_valid, grant_idx[SW].

The FSM and push pipeline stay in the top module.

Test Plan:
1. Reset, init=1 with af=6/ae=2 for 2 cycles, init=0 -> state INIT then IDLE; umbral_af_out=6, umbral_ae_out=2.
2. Config with af=3, ae=3, drop init -> state ERROR (10000), error_out=1; stays there until reset=1.
3. All 4 queues non-empty, out_almost_full=0 -> pop sequence 0001,0010,0100,1000,0001; push_out=1 each following cycle; sel 0,1,2,3,0; data_out matches the queue data.
4. Only queue 2 non-empty for 3 cycles, then queue 0 also non-empty -> pop=0100 x3, then 0001 (rr_ptr wrapped from 3 to 0); queue 2 then follows.
5. out_almost_full=1 mid-stream -> pop=0 in the same cycle; one pending push_out still appears; pops resume from the correct rr_ptr when the flag drops.
6. fifo_error_in[1]=1 during ACTIVE -> ERROR next edge, pop/push_out=0; reset asserted mid-transfer -> RESET, push_out=0, rr_ptr=0.
